// File: rtl/serial_addsub.sv
`timescale 1ns/1ps
// Digit-serial adder/subtractor: adds or subtracts two WIDTH-bit operands
// DIGIT bits per clock, with valid/ready handshakes on both sides.
// Ports: clk, rst (sync, active high); in_valid/in_ready with a, b, sub;
// out_valid/out_ready with sum, carry_out (1 = no borrow when sub),
// overflow (two's-complement signed overflow).
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    // Guarded divisor keeps elaboration sane long enough to report a bad DIGIT.
    localparam int DIG_S = (DIGIT < 1) ? 1 : DIGIT;
    localparam int N     = WIDTH / DIG_S;
    localparam int CW    = (N > 1) ? $clog2(N) : 1;

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIG_S) != 0) begin : g_bad_cfg
            $error("serial_addsub: DIGIT must be in 1..WIDTH and divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] ad;
    logic [DIGIT-1:0] bd;
    logic [DIGIT:0]   dsum;
    logic             cin_msb;
    logic             last;

    // Current digit slice of each registered operand.
    assign ad   = a_q[cnt_q*DIGIT +: DIGIT];
    assign bd   = b_q[cnt_q*DIGIT +: DIGIT];
    assign dsum = {1'b0, ad} + {1'b0, bd} + {{DIGIT{1'b0}}, carry_q};
    assign last = (cnt_q == CW'(N - 1));

    // Carry into the top bit of the digit recovered from the sum bit itself.
    assign cin_msb = ad[DIGIT-1] ^ bd[DIGIT-1] ^ dsum[DIGIT-1];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction as a + ~b + 1: invert b, seed carry with 1.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[cnt_q*DIGIT +: DIGIT] = dsum[DIGIT-1:0];
                carry_d = dsum[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    cout_d  = dsum[DIGIT];
                    ovf_d   = cin_msb ^ dsum[DIGIT];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
`timescale 1ns/1ps
// Bench for serial_addsub: table vectors, DONE hold, reset mid-run,
// single-digit configuration and random operations against a model.
module tb_serial_addsub;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] s;
        logic        c;
        logic        v;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid0, in_ready0, sub0, out_valid0, out_ready0;
    logic [15:0] a0, b0, sum0;
    logic        cout0, ovf0;
    logic        in_valid1, in_ready1, sub1, out_valid1, out_ready1;
    logic [15:0] a1, b1, sum1;
    logic        cout1, ovf1;

    int   nasserts = 0;
    int   nfail    = 0;
    vec_t q0[$];
    vec_t q1[$];

    serial_addsub #(.WIDTH(16), .DIGIT(4)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid0), .in_ready(in_ready0),
        .a(a0), .b(b0), .sub(sub0),
        .out_valid(out_valid0), .out_ready(out_ready0),
        .sum(sum0), .carry_out(cout0), .overflow(ovf0)
    );

    serial_addsub #(.WIDTH(16), .DIGIT(16)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .sub(sub1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .carry_out(cout1), .overflow(ovf1)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nasserts++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic s);
        vec_t r;
        logic [16:0] f;
        int sa, sb, rs;
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (s) begin
            f  = {1'b0, a} - {1'b0, b};
            rs = sa - sb;
            r.c = (a >= b);
        end else begin
            f  = {1'b0, a} + {1'b0, b};
            rs = sa + sb;
            r.c = f[16];
        end
        r.a = a;
        r.b = b;
        r.sub = s;
        r.s = f[15:0];
        r.v = (rs > 32767) || (rs < -32768);
        return r;
    endfunction

    // Called and returns at a falling edge.
    task automatic op0(input vec_t e, input int hold);
        int   lat;
        int   g;
        vec_t x;
        g = 0;
        while (!in_ready0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("in_ready0", in_ready0, 1);
        a0 = e.a; b0 = e.b; sub0 = e.sub; in_valid0 = 1'b1;
        q0.push_back(e);
        @(posedge clk);
        #1;
        lat = 0;
        do begin
            in_valid0 = 1'($urandom);
            a0 = 16'($urandom);
            b0 = 16'($urandom);
            sub0 = 1'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid0 && lat < 20);
        chk("latency0", lat, 4);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", out_valid0, 1);
            chk("hold_ready", in_ready0, 0);
            chk("hold_sum", sum0, e.s);
            chk("hold_cout", cout0, e.c);
            chk("hold_ovf", ovf0, e.v);
            in_valid0 = 1'($urandom);
            a0 = 16'($urandom);
            b0 = 16'($urandom);
            @(negedge clk);
        end
        in_valid0 = 1'b0;
        out_ready0 = 1'b1;
        if (q0.size() == 0) begin
            chk("sb0_empty", 1, 0);
        end else begin
            x = q0.pop_front();
            chk("out_valid0", out_valid0, 1);
            chk("sum0", sum0, x.s);
            chk("cout0", cout0, x.c);
            chk("ovf0", ovf0, x.v);
        end
        @(negedge clk);
        out_ready0 = 1'b0;
        chk("idle_ready0", in_ready0, 1);
        chk("idle_valid0", out_valid0, 0);
    endtask

    task automatic op1(input vec_t e);
        int   lat;
        vec_t x;
        chk("in_ready1", in_ready1, 1);
        a1 = e.a; b1 = e.b; sub1 = e.sub; in_valid1 = 1'b1;
        q1.push_back(e);
        @(posedge clk);
        #1;
        in_valid1 = 1'b0;
        a1 = 16'($urandom);
        b1 = 16'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid1 && lat < 20);
        chk("latency1", lat, 1);
        out_ready1 = 1'b1;
        x = q1.pop_front();
        chk("sum1", sum1, x.s);
        chk("cout1", cout1, x.c);
        chk("ovf1", ovf1, x.v);
        @(negedge clk);
        out_ready1 = 1'b0;
        chk("idle_ready1", in_ready1, 1);
    endtask

    vec_t tbl[10];

    initial begin
        tbl[0] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[3] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        tbl[8] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};
        tbl[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1;
        in_valid0 = 0; a0 = 0; b0 = 0; sub0 = 0; out_ready0 = 0;
        in_valid1 = 0; a1 = 0; b1 = 0; sub1 = 0; out_ready1 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", in_ready0, 1);
        chk("rst_valid0", out_valid0, 0);
        chk("rst_sum0", sum0, 0);
        chk("rst_cout0", cout0, 0);
        chk("rst_ovf0", ovf0, 0);
        chk("rst_ready1", in_ready1, 1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            op0(tbl[i], (i == 1) ? 5 : (i % 3));
        end

        // Reset on the second RUN cycle discards the operation.
        a0 = 16'h1111; b0 = 16'h2222; sub0 = 1'b0; in_valid0 = 1'b1;
        @(posedge clk);
        #1 in_valid0 = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", in_ready0, 1);
        chk("midrst_valid", out_valid0, 0);
        chk("midrst_sum", sum0, 0);
        chk("midrst_cout", cout0, 0);
        chk("midrst_ovf", ovf0, 0);
        op0(model(16'h1111, 16'h2222, 1'b0), 0);

        op1(tbl[7]);
        for (int i = 0; i < 200; i++) begin
            op1(model(16'($urandom), 16'($urandom), 1'(i % 2)));
        end

        for (int i = 0; i < 1000; i++) begin
            op0(model(16'($urandom), 16'($urandom), 1'(i % 2)),
                int'($urandom_range(0, 2)));
        end

        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nasserts, nfail);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, bits processed per clock cycle.
REQ-003 The block SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid  input  1  operands and mode presented.
REQ-006 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-007 The block SHALL have port a  input  WIDTH  first operand.
REQ-008 The block SHALL have port b  input  WIDTH  second operand.
REQ-009 The block SHALL have port sub  input  1  mode: 0 gives a+b, 1 gives a-b.
REQ-010 The block SHALL have port out_valid  output  1  result available.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 The block SHALL have port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 The block SHALL have port carry_out  output  1  carry out of the MSB; in sub mode, 1 means no borrow.
REQ-014 The block SHALL have port overflow  output  1  two's-complement signed overflow.

Function
REQ-015 Elaboration SHALL fail if WIDTH % DIGIT != 0, if DIGIT > WIDTH, or if DIGIT < 1; N = WIDTH/DIGIT.
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 Handshake SHALL occur on a rising edge with in_valid=1 and in_ready=1.
REQ-019 On handshake, the block SHALL register a, b XOR {WIDTH{sub}}, and carry=sub; the digit counter SHALL be set to 0 and the state SHALL become RUN.
REQ-020 On each RUN edge, the block SHALL add digit cnt of both registered operands plus carry, write the DIGIT result bits to sum[cnt*DIGIT +: DIGIT], update carry, and increment cnt.
REQ-021 On the RUN edge with cnt == N-1, the block SHALL also latch carry_out = final carry and overflow = carry into MSB XOR carry out of MSB, then go to DONE.
REQ-022 Latency: out_valid SHALL be high exactly N cycles after the handshake edge (N=4 at defaults; N=1 when DIGIT=WIDTH).
REQ-023 In DONE, sum, carry_out and overflow SHALL be held stable until an edge with out_ready=1.
REQ-024 On that out_ready edge, the state SHALL become IDLE and in_ready SHALL be 1 in the next cycle; there is no same-cycle bypass.
REQ-025 in_valid, a, b and sub SHALL be ignored outside IDLE; operand changes during RUN SHALL NOT affect the result.
REQ-026 Throughput SHALL be one operation per N+2 cycles at most.
REQ-027 sum, carry_out and overflow SHALL be meaningful only while out_valid=1, and SHALL NOT be cleared on leaving DONE.

Reset
REQ-028 When rst=1 at a rising edge, the state SHALL become IDLE, cnt and carry SHALL become 0, and sum, carry_out and overflow SHALL become 0.
REQ-029 After reset, out_valid SHALL be 0 and in_ready SHALL be 1 in the following cycle.
REQ-030 rst SHALL take priority over all handshakes; reset during RUN or DONE SHALL discard the operation with no output.

Verification (WIDTH=16, DIGIT=4 unless stated)
REQ-031 a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, carry_out=0, overflow=1; out_valid rises 4 cycles after the handshake.
REQ-032 a=0xFFFF, b=0x0001, sub=0 -> sum=0x0000, carry_out=1, overflow=0.
REQ-033 a=0x0003, b=0x0005, sub=1 -> sum=0xFFFE, carry_out=0, overflow=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, carry_out=1, overflow=1.
REQ-034 Hold out_ready=0 for 5 cycles in DONE while toggling in_valid, a and b -> outputs stay constant and in_ready=0; raise out_ready -> IDLE on the next edge.
REQ-035 Assert rst on the 2nd RUN cycle -> next cycle in_ready=1, out_valid=0, all outputs 0; a fresh operation then completes correctly.
REQ-036 With DIGIT=16, a=0x1234, b=0x4321, sub=0 -> sum=0x5555, out_valid 1 cycle after the handshake; the bench SHALL also run 1000 random operations against a reference model in both modes.
